// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: stall/bubble generation for load-use, mispredict, ret and exceptions.
// Optional saturating event counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] D_icode_i,
  input  logic [3:0] E_icode_i,
  input  logic [3:0] E_dstM_i,
  input  logic [3:0] d_srcA_i,
  input  logic [3:0] d_srcB_i,
  input  logic       e_Cnd_i,
  input  logic [2:0] m_stat_i,
  input  logic [2:0] W_stat_i,
  output logic       F_stall_o,
  output logic       D_stall_o,
  output logic       D_bubble_o,
  output logic       E_bubble_o,
  output logic       M_bubble_o,
  output logic       W_stall_o,
  output logic       halted_o
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] lu_cnt_o,
  output logic [CNT_W-1:0] mp_cnt_o,
  output logic [CNT_W-1:0] ret_cnt_o
`endif
);

  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [3:0] RNONE   = 4'hF;
  localparam logic [2:0] SAOK    = 3'd1;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    RET_E = 2'd1,
    RET_M = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic load_use;
  logic mispred;
  logic exc_m;
  logic exc_w;
  logic ret_busy;
  logic ret_start;

  always_comb begin
    load_use = ((E_icode_i == IMRMOVQ) || (E_icode_i == IPOPQ)) &&
               (E_dstM_i != RNONE) &&
               ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
    mispred  = (E_icode_i == IJXX) && !e_Cnd_i;
    exc_m    = (m_stat_i != SAOK);
    exc_w    = (W_stat_i != SAOK);
    ret_busy = ((state_q == RUN) && (D_icode_i == IRET)) ||
               (state_q == RET_E) || (state_q == RET_M);
  end

  // A ret held by load-use or squashed by mispredict never starts the RET_E/RET_M walk.
  always_comb begin
    state_d   = state_q;
    ret_start = 1'b0;
    if (exc_w) begin
      state_d = HALT;
    end else begin
      unique case (state_q)
        RUN: begin
          if ((D_icode_i == IRET) && !load_use && !mispred) begin
            state_d   = RET_E;
            ret_start = 1'b1;
          end
        end
        RET_E:   state_d = RET_M;
        RET_M:   state_d = RUN;
        HALT:    state_d = HALT;
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    F_stall_o  = load_use || ret_busy;
    D_stall_o  = load_use;
    D_bubble_o = mispred || (ret_busy && !load_use);
    E_bubble_o = mispred || load_use;
    M_bubble_o = exc_m || exc_w;
    W_stall_o  = exc_w;
    halted_o   = 1'b0;
    if (state_q == HALT) begin
      F_stall_o  = 1'b1;
      D_stall_o  = 1'b0;
      D_bubble_o = 1'b1;
      E_bubble_o = 1'b1;
      M_bubble_o = 1'b1;
      W_stall_o  = 1'b1;
      halted_o   = 1'b1;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] lu_cnt_q;
  logic [CNT_W-1:0] mp_cnt_q;
  logic [CNT_W-1:0] ret_cnt_q;
  logic             cnt_en;

  assign cnt_en = (state_q != HALT);

  // Counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lu_cnt_q  <= '0;
      mp_cnt_q  <= '0;
      ret_cnt_q <= '0;
    end else if (cnt_en) begin
      if (load_use && (lu_cnt_q != '1)) begin
        lu_cnt_q <= lu_cnt_q + CNT_W'(1);
      end
      if (mispred && (mp_cnt_q != '1)) begin
        mp_cnt_q <= mp_cnt_q + CNT_W'(1);
      end
      if (ret_start && (ret_cnt_q != '1)) begin
        ret_cnt_q <= ret_cnt_q + CNT_W'(1);
      end
    end
  end

  assign lu_cnt_o  = lu_cnt_q;
  assign mp_cnt_o  = mp_cnt_q;
  assign ret_cnt_o = ret_cnt_q;
`endif

endmodule
